// File: rtl/vertexinput_mem_arbiter.sv
// rtl/vertexinput_mem_arbiter.sv - round-robin arbiter sharing one register-file request port between two requesters
module vertexinput_mem_arbiter #(
    parameter int                ADDR_W         = 32,
    parameter int                DATA_W         = 32,
    parameter int                TIMEOUT_CYCLES = 64,
    parameter logic [DATA_W-1:0] ERR_DATA       = DATA_W'(32'hDEAD_BEEF)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                s0_w_req,
    input  logic [ADDR_W-1:0]   s0_w_addr,
    input  logic [DATA_W-1:0]   s0_w_data,
    input  logic [DATA_W/8-1:0] s0_w_strb,
    output logic                s0_w_ack,
    input  logic                s0_r_req,
    input  logic [ADDR_W-1:0]   s0_r_addr,
    output logic [DATA_W-1:0]   s0_r_data,
    output logic                s0_r_ack,
    output logic                s0_err,
    input  logic                s1_w_req,
    input  logic [ADDR_W-1:0]   s1_w_addr,
    input  logic [DATA_W-1:0]   s1_w_data,
    input  logic [DATA_W/8-1:0] s1_w_strb,
    output logic                s1_w_ack,
    input  logic                s1_r_req,
    input  logic [ADDR_W-1:0]   s1_r_addr,
    output logic [DATA_W-1:0]   s1_r_data,
    output logic                s1_r_ack,
    output logic                s1_err,
    output logic                m_w_req,
    output logic [ADDR_W-1:0]   m_w_addr,
    output logic [DATA_W-1:0]   m_w_data,
    output logic [DATA_W/8-1:0] m_w_strb,
    input  logic                m_w_ack,
    output logic                m_r_req,
    output logic [ADDR_W-1:0]   m_r_addr,
    input  logic [DATA_W-1:0]   m_r_data,
    input  logic                m_r_ack,
    output logic [7:0]          timeout_cnt
);

    localparam int STRB_W = DATA_W / 8;
    localparam int TCNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

    state_t              state_q, state_d;
    logic [1:0]          rr_q, rr_d;
    logic [1:0]          grant_q, grant_d;
    logic [TCNT_W-1:0]   tcnt_q, tcnt_d;
    logic                m_w_req_q, m_w_req_d;
    logic [ADDR_W-1:0]   m_w_addr_q, m_w_addr_d;
    logic [DATA_W-1:0]   m_w_data_q, m_w_data_d;
    logic [STRB_W-1:0]   m_w_strb_q, m_w_strb_d;
    logic                m_r_req_q, m_r_req_d;
    logic [ADDR_W-1:0]   m_r_addr_q, m_r_addr_d;
    logic [3:0]          ack_q, ack_d;
    logic [1:0]          err_q, err_d;
    logic [DATA_W-1:0]   s0_r_data_q, s0_r_data_d;
    logic [DATA_W-1:0]   s1_r_data_q, s1_r_data_d;
    logic [7:0]          timeout_cnt_q, timeout_cnt_d;

    logic [3:0]          pending;
    logic [1:0]          idx;
    logic [1:0]          pick;
    logic                pick_valid;
    logic                hit;
    logic                finish;
    logic [DATA_W-1:0]   rd_val;

    always_comb begin
        state_d       = state_q;
        rr_d          = rr_q;
        grant_d       = grant_q;
        tcnt_d        = tcnt_q;
        m_w_req_d     = m_w_req_q;
        m_w_addr_d    = m_w_addr_q;
        m_w_data_d    = m_w_data_q;
        m_w_strb_d    = m_w_strb_q;
        m_r_req_d     = m_r_req_q;
        m_r_addr_d    = m_r_addr_q;
        ack_d         = '0;
        err_d         = '0;
        s0_r_data_d   = s0_r_data_q;
        s1_r_data_d   = s1_r_data_q;
        timeout_cnt_d = timeout_cnt_q;
        pending       = {s1_r_req, s1_w_req, s0_r_req, s0_w_req};
        idx           = '0;
        pick          = '0;
        pick_valid    = 1'b0;
        hit           = 1'b0;
        finish        = 1'b0;
        rd_val        = m_r_data;

        // Search starts at the rr pointer so the last-served source goes to the back of the line.
        for (int i = 0; i < 4; i++) begin
            idx = rr_q + 2'(i);
            if (!pick_valid && pending[idx]) begin
                pick_valid = 1'b1;
                pick       = idx;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    grant_d = pick;
                    rr_d    = pick + 2'd1;
                    tcnt_d  = '0;
                    state_d = ST_WAIT;
                    case (pick)
                        2'd0: begin
                            m_w_req_d  = 1'b1;
                            m_w_addr_d = s0_w_addr;
                            m_w_data_d = s0_w_data;
                            m_w_strb_d = s0_w_strb;
                        end
                        2'd1: begin
                            m_r_req_d  = 1'b1;
                            m_r_addr_d = s0_r_addr;
                        end
                        2'd2: begin
                            m_w_req_d  = 1'b1;
                            m_w_addr_d = s1_w_addr;
                            m_w_data_d = s1_w_data;
                            m_w_strb_d = s1_w_strb;
                        end
                        default: begin
                            m_r_req_d  = 1'b1;
                            m_r_addr_d = s1_r_addr;
                        end
                    endcase
                end
            end
            ST_WAIT: begin
                // Odd grant indices are reads; only the ack of the issued kind completes the access.
                hit = grant_q[0] ? m_r_ack : m_w_ack;
                if (hit) begin
                    finish = 1'b1;
                end else if (tcnt_q == TCNT_LAST) begin
                    finish             = 1'b1;
                    rd_val             = ERR_DATA;
                    err_d[grant_q[1]]  = 1'b1;
                    if (timeout_cnt_q != 8'hFF) begin
                        timeout_cnt_d = timeout_cnt_q + 8'd1;
                    end
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
                if (finish) begin
                    m_w_req_d      = 1'b0;
                    m_r_req_d      = 1'b0;
                    ack_d[grant_q] = 1'b1;
                    state_d        = ST_RESP;
                    if (grant_q == 2'd1) begin
                        s0_r_data_d = rd_val;
                    end else if (grant_q == 2'd3) begin
                        s1_r_data_d = rd_val;
                    end
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            rr_q          <= '0;
            grant_q       <= '0;
            tcnt_q        <= '0;
            m_w_req_q     <= 1'b0;
            m_w_addr_q    <= '0;
            m_w_data_q    <= '0;
            m_w_strb_q    <= '0;
            m_r_req_q     <= 1'b0;
            m_r_addr_q    <= '0;
            ack_q         <= '0;
            err_q         <= '0;
            s0_r_data_q   <= '0;
            s1_r_data_q   <= '0;
            timeout_cnt_q <= '0;
        end else begin
            state_q       <= state_d;
            rr_q          <= rr_d;
            grant_q       <= grant_d;
            tcnt_q        <= tcnt_d;
            m_w_req_q     <= m_w_req_d;
            m_w_addr_q    <= m_w_addr_d;
            m_w_data_q    <= m_w_data_d;
            m_w_strb_q    <= m_w_strb_d;
            m_r_req_q     <= m_r_req_d;
            m_r_addr_q    <= m_r_addr_d;
            ack_q         <= ack_d;
            err_q         <= err_d;
            s0_r_data_q   <= s0_r_data_d;
            s1_r_data_q   <= s1_r_data_d;
            timeout_cnt_q <= timeout_cnt_d;
        end
    end

    assign s0_w_ack    = ack_q[0];
    assign s0_r_ack    = ack_q[1];
    assign s1_w_ack    = ack_q[2];
    assign s1_r_ack    = ack_q[3];
    assign s0_err      = err_q[0];
    assign s1_err      = err_q[1];
    assign s0_r_data   = s0_r_data_q;
    assign s1_r_data   = s1_r_data_q;
    assign m_w_req     = m_w_req_q;
    assign m_w_addr    = m_w_addr_q;
    assign m_w_data    = m_w_data_q;
    assign m_w_strb    = m_w_strb_q;
    assign m_r_req     = m_r_req_q;
    assign m_r_addr    = m_r_addr_q;
    assign timeout_cnt = timeout_cnt_q;

endmodule

// File: tb/tb_vertexinput_mem_arbiter.sv
// tb/tb_vertexinput_mem_arbiter.sv - self-checking bench for vertexinput_mem_arbiter
module tb_vertexinput_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        req   [0:3];
    logic [31:0] addr  [0:3];
    logic [31:0] wdata [0:3];
    logic [3:0]  wstrb [0:3];

    logic        s0_w_ack, s0_r_ack, s0_err, s1_w_ack, s1_r_ack, s1_err;
    logic [31:0] s0_r_data, s1_r_data;
    logic        m_w_req, m_r_req;
    logic [31:0] m_w_addr, m_w_data, m_r_addr;
    logic [3:0]  m_w_strb;
    logic        m_w_ack, m_r_ack;
    logic [31:0] m_r_data;
    logic [7:0]  timeout_cnt;
    logic [3:0]  ack_vec;

    int n_checks = 0;
    int n_pass   = 0;

    // downstream responder controls
    int          ds_lat   = 1;
    bit          ds_rand  = 0;
    bit          ds_never = 0;
    bit          ds_fixed = 0;
    logic [31:0] ds_fixed_data = '0;
    int          ds_cnt   = 0;
    int          cur_lat  = 0;
    bit          ds_done  = 0;
    logic [31:0] last_w_addr, last_w_data;

    // round-robin reference model
    bit          mon_on  = 0;
    int          mon_ptr = 0;
    logic [3:0]  prev_req = '0;
    logic        prev_m   = 1'b0;
    int          grant_log [$];

    vertexinput_mem_arbiter #(
        .ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(8), .ERR_DATA(32'hDEAD_BEEF)
    ) dut (
        .clk(clk), .rst(rst),
        .s0_w_req(req[0]), .s0_w_addr(addr[0]), .s0_w_data(wdata[0]), .s0_w_strb(wstrb[0]),
        .s0_w_ack(s0_w_ack),
        .s0_r_req(req[1]), .s0_r_addr(addr[1]), .s0_r_data(s0_r_data), .s0_r_ack(s0_r_ack),
        .s0_err(s0_err),
        .s1_w_req(req[2]), .s1_w_addr(addr[2]), .s1_w_data(wdata[2]), .s1_w_strb(wstrb[2]),
        .s1_w_ack(s1_w_ack),
        .s1_r_req(req[3]), .s1_r_addr(addr[3]), .s1_r_data(s1_r_data), .s1_r_ack(s1_r_ack),
        .s1_err(s1_err),
        .m_w_req(m_w_req), .m_w_addr(m_w_addr), .m_w_data(m_w_data), .m_w_strb(m_w_strb),
        .m_w_ack(m_w_ack),
        .m_r_req(m_r_req), .m_r_addr(m_r_addr), .m_r_data(m_r_data), .m_r_ack(m_r_ack),
        .timeout_cnt(timeout_cnt)
    );

    assign ack_vec = {s1_r_ack, s1_w_ack, s0_r_ack, s0_w_ack};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rd_fn(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h5A5A_0F0F;
    endfunction

    function automatic int rr_pick(input logic [3:0] pend, input int ptr);
        for (int i = 0; i < 4; i++) begin
            if (pend[(ptr + i) % 4]) return (ptr + i) % 4;
        end
        return -1;
    endfunction

    // downstream memory model: acks after a programmable latency, once per request
    always @(posedge clk) begin
        #1;
        m_w_ack  = 1'b0;
        m_r_ack  = 1'b0;
        m_r_data = $urandom;
        if (m_w_req || m_r_req) begin
            if (ds_cnt == 0) cur_lat = ds_rand ? $urandom_range(0, 4) : ds_lat;
            if (!ds_never && !ds_done && ds_cnt == cur_lat) begin
                if (m_w_req) begin
                    m_w_ack     = 1'b1;
                    last_w_addr = m_w_addr;
                    last_w_data = m_w_data;
                end else begin
                    m_r_ack  = 1'b1;
                    m_r_data = ds_fixed ? ds_fixed_data : rd_fn(m_r_addr);
                end
                ds_done = 1;
            end
            ds_cnt++;
        end else begin
            ds_cnt  = 0;
            ds_done = 0;
        end
    end

    // grant monitor: source is identified by request kind plus address bit 31 (port)
    always @(negedge clk) begin
        int src, exp_src;
        if (mon_on && (m_w_req || m_r_req) && !prev_m) begin
            src     = m_w_req ? (m_w_addr[31] ? 2 : 0) : (m_r_addr[31] ? 3 : 1);
            exp_src = rr_pick(prev_req, mon_ptr);
            n_checks++;
            if (src === exp_src && !(m_w_req && m_r_req) &&
                (m_w_req ? (m_w_addr === addr[src] && m_w_data === wdata[src] && m_w_strb === wstrb[src])
                         : (m_r_addr === addr[src])))
                n_pass++;
            else
                $display("FAIL grant_order: granted %0d (w=%b r=%b) required %0d with matching payload",
                         src, m_w_req, m_r_req, exp_src);
            grant_log.push_back(src);
            mon_ptr = (src + 1) % 4;
        end
        prev_m   = m_w_req | m_r_req;
        prev_req = {req[3], req[2], req[1], req[0]};
    end

    task automatic apply_reset();
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req[i] = 1'b0; addr[i] = '0; wdata[i] = '0; wstrb[i] = '0;
        end
        ds_never = 0; ds_rand = 0; ds_fixed = 0; ds_lat = 1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic run_src(input int s, input int nops, input int maxgap);
        bit got;
        for (int k = 0; k < nops; k++) begin
            repeat ($urandom_range(0, maxgap)) @(posedge clk);
            @(posedge clk); #1;
            addr[s]  = ($urandom & 32'h7FFF_FFFC) | ((s >= 2) ? 32'h8000_0000 : 32'h0);
            wdata[s] = $urandom;
            wstrb[s] = 4'($urandom);
            req[s]   = 1'b1;
            got = 0;
            for (int c = 0; c < 100 && !got; c++) begin
                @(negedge clk);
                if (ack_vec[s]) got = 1;
            end
            n_checks++;
            if (got && ((s < 2) ? s0_err : s1_err) === 1'b0 &&
                (s == 1 ? s0_r_data === rd_fn(addr[s]) : s == 3 ? s1_r_data === rd_fn(addr[s]) : 1'b1))
                n_pass++;
            else
                $display("FAIL src%0d_op%0d: got_ack=%0d err0=%b err1=%b rd0=%h rd1=%h required ack, err=0, rd=%h",
                         s, k, got, s0_err, s1_err, s0_r_data, s1_r_data, rd_fn(addr[s]));
            @(posedge clk); #1;
            req[s] = 1'b0;
        end
    endtask

    task automatic test_reset();
        apply_reset();
        @(negedge clk);
        n_checks++;
        if ({m_w_req, m_r_req, ack_vec, s0_err, s1_err} === 8'h00) n_pass++;
        else $display("FAIL reset_ctrl: req/ack/err=%b required 0", {m_w_req, m_r_req, ack_vec, s0_err, s1_err});
        n_checks++;
        if ({m_w_addr, m_w_data, m_w_strb, m_r_addr} === '0) n_pass++;
        else $display("FAIL reset_payload: %h %h %h %h required 0", m_w_addr, m_w_data, m_w_strb, m_r_addr);
        n_checks++;
        if ({s0_r_data, s1_r_data, timeout_cnt} === '0) n_pass++;
        else $display("FAIL reset_rdata: %h %h cnt=%0d required 0", s0_r_data, s1_r_data, timeout_cnt);
    endtask

    task automatic test_single_write();
        int k_ack = -1;
        bit m_ok = 0;
        apply_reset();
        ds_lat = 2;
        @(posedge clk); #1;
        addr[0] = 32'h04; wdata[0] = 32'h0000_00A5; wstrb[0] = 4'hF; req[0] = 1'b1;
        @(negedge clk);
        for (int k = 1; k <= 20 && k_ack < 0; k++) begin
            @(negedge clk);
            if (k == 1) m_ok = (m_w_req === 1'b1 && m_w_data === 32'hA5 && m_w_addr === 32'h04 && m_w_strb === 4'hF);
            if (s0_w_ack) k_ack = k;
        end
        n_checks++;
        if (m_ok) n_pass++;
        else $display("FAIL wr_downstream: m_w_req/payload not presented 1 cycle after request (data=%h) required a5", m_w_data);
        n_checks++;
        if (k_ack == 4 && s0_err === 1'b0 && ack_vec === 4'b0001) n_pass++;
        else $display("FAIL wr_ack: ack at cycle %0d err=%b acks=%b required cycle 4 err=0 acks=0001", k_ack, s0_err, ack_vec);
        @(posedge clk); #1 req[0] = 1'b0;
        @(negedge clk);
        n_checks++;
        if (s0_w_ack === 1'b0) n_pass++;
        else $display("FAIL wr_ack_pulse: s0_w_ack=%b required 0", s0_w_ack);
    endtask

    task automatic test_single_read();
        int  k_ack = -1;
        bit  other = 0;
        apply_reset();
        ds_lat = 1; ds_fixed = 1; ds_fixed_data = 32'h1234_5678;
        @(posedge clk); #1;
        addr[3] = 32'h08; req[3] = 1'b1;
        @(negedge clk);
        for (int k = 1; k <= 20 && k_ack < 0; k++) begin
            @(negedge clk);
            if (s0_w_ack || s0_r_ack || s1_w_ack) other = 1;
            if (s1_r_ack) k_ack = k;
        end
        n_checks++;
        if (k_ack == 3 && s1_r_data === 32'h1234_5678 && s1_err === 1'b0) n_pass++;
        else $display("FAIL rd_p1: ack cycle %0d data=%h err=%b required cycle 3 data=12345678 err=0", k_ack, s1_r_data, s1_err);
        n_checks++;
        if (!other) n_pass++;
        else $display("FAIL rd_p1_other: stray ack observed required none");
        @(posedge clk); #1 req[3] = 1'b0;
        ds_fixed = 0;
    endtask

    task automatic test_round_robin();
        int exp_seq [12] = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 1, 2, 3};
        apply_reset();
        grant_log.delete();
        mon_ptr = 0; mon_on = 1; ds_lat = 1;
        fork
            run_src(0, 3, 0);
            run_src(1, 3, 0);
            run_src(2, 3, 0);
            run_src(3, 3, 0);
        join
        mon_on = 0;
        n_checks++;
        if (grant_log.size() == 12) n_pass++;
        else $display("FAIL rr_count: %0d grants required 12", grant_log.size());
        for (int i = 0; i < 12 && i < grant_log.size(); i++) begin
            n_checks++;
            if (grant_log[i] == exp_seq[i]) n_pass++;
            else $display("FAIL rr_seq[%0d]: granted %0d required %0d", i, grant_log[i], exp_seq[i]);
        end
    endtask

    task automatic test_timeout();
        int k_ack = -1;
        int hi    = 0;
        apply_reset();
        ds_never = 1;
        @(posedge clk); #1;
        addr[1] = 32'h10; req[1] = 1'b1;
        @(negedge clk);
        for (int k = 1; k <= 30 && k_ack < 0; k++) begin
            @(negedge clk);
            if (m_r_req) hi++;
            if (s0_r_ack) k_ack = k;
        end
        n_checks++;
        if (k_ack == 9 && hi == 8 && m_r_req === 1'b0) n_pass++;
        else $display("FAIL to_timing: ack cycle %0d req_cycles %0d required 9 and 8", k_ack, hi);
        n_checks++;
        if (s0_err === 1'b1 && s0_r_data === 32'hDEAD_BEEF && timeout_cnt === 8'd1) n_pass++;
        else $display("FAIL to_result: err=%b data=%h cnt=%0d required 1 deadbeef 1", s0_err, s0_r_data, timeout_cnt);
        @(posedge clk); #1 req[1] = 1'b0;
        ds_never = 0;
    endtask

    task automatic test_reset_mid();
        bit got = 0;
        apply_reset();
        ds_never = 1;
        @(posedge clk); #1;
        addr[1] = 32'h30; req[1] = 1'b1;
        repeat (4) @(negedge clk);
        n_checks++;
        if (m_r_req === 1'b1) n_pass++;
        else $display("FAIL mid_wait: m_r_req=%b required 1", m_r_req);
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({m_r_req, m_w_req, ack_vec, s0_err, s1_err} === 8'h00 && m_r_addr === 32'h0 && timeout_cnt === 8'd0) n_pass++;
        else $display("FAIL mid_reset: req/ack=%b addr=%h required all 0", {m_r_req, m_w_req, ack_vec}, m_r_addr);
        req[1] = 1'b0; ds_never = 0; ds_lat = 1;
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;
        addr[2] = 32'h20; wdata[2] = 32'h0000_CAFE; wstrb[2] = 4'h3; req[2] = 1'b1;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            if (s1_w_ack) got = 1;
        end
        n_checks++;
        if (got && s1_err === 1'b0 && last_w_data === 32'h0000_CAFE && last_w_addr === 32'h20) n_pass++;
        else $display("FAIL mid_recover: ack=%0d err=%b data=%h required 1 0 0000cafe", got, s1_err, last_w_data);
        @(posedge clk); #1 req[2] = 1'b0;
    endtask

    task automatic test_saturate();
        int  errs = 0;
        bit  got;
        apply_reset();
        ds_never = 1;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk); #1;
            addr[2] = 32'h40; wdata[2] = i; wstrb[2] = 4'hF; req[2] = 1'b1;
            got = 0;
            for (int c = 0; c < 30 && !got; c++) begin
                @(negedge clk);
                if (s1_w_ack) begin got = 1; if (s1_err) errs++; end
            end
            if (i == 0 || i == 254) begin
                n_checks++;
                if (timeout_cnt === ((i == 0) ? 8'd1 : 8'd255)) n_pass++;
                else $display("FAIL sat_cnt_%0d: cnt=%0d required %0d", i, timeout_cnt, (i == 0) ? 1 : 255);
            end
            @(posedge clk); #1 req[2] = 1'b0;
        end
        n_checks++;
        if (timeout_cnt === 8'd255 && errs == 300) n_pass++;
        else $display("FAIL sat_final: cnt=%0d errs=%0d required 255 300", timeout_cnt, errs);
        ds_never = 0;
    endtask

    task automatic test_random();
        apply_reset();
        grant_log.delete();
        mon_ptr = 0; mon_on = 1; ds_rand = 1;
        fork
            run_src(0, 25, 3);
            run_src(1, 25, 3);
            run_src(2, 25, 3);
            run_src(3, 25, 3);
        join
        mon_on = 0; ds_rand = 0;
        n_checks++;
        if (grant_log.size() == 100) n_pass++;
        else $display("FAIL rand_grants: %0d grants required 100", grant_log.size());
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_single_read();
        test_round_robin();
        test_timeout();
        test_reset_mid();
        test_saturate();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("%0d/%0d checks passed", n_pass, n_checks + 1);
        $fatal(1);
    end

endmodule
